// File: rtl/io_bridge_pkg.sv
// Shared types and helpers for the io_bridge peripheral interface.
package io_bridge_pkg;

  // Interrupt pulse generator states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    HOLD = 2'd2
  } itr_state_t;

  // Lowest bit of port k inside a flattened bus of w-bit ports
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/io_in_slot.sv
// One-deep input buffer: captures from an external producer, released by a core read.
module io_in_slot #(
  parameter int NUBITS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUBITS-1:0] load_data,
  input  logic              load_vld,
  input  logic              take,
  output logic              rdy,
  output logic              capture,
  output logic [NUBITS-1:0] data
);

  logic full;

  // Ready comes straight from the flag so a core read never ripples into the producer side
  assign rdy     = ~full;
  assign capture = load_vld & ~full;

  // Capture has priority: it only happens when empty, where a read would leave the flag alone anyway
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      data <= '0;
    end else if (capture) begin
      full <= 1'b1;
      data <= load_data;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/io_bridge.sv
// Peripheral side of the core I/O interface: input buffers, output registers, interrupt pulse.
module io_bridge
  import io_bridge_pkg::*;
#(
  parameter int                NUBITS = 32,
  parameter int                NUIOIN = 8,
  parameter int                NUIOOU = 8,
  parameter logic [NUIOIN-1:0] ITRMSK = {NUIOIN{1'b0}},
  parameter int                ITRHLD = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_in,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  output logic [NUBITS-1:0]          io_in,
  input  logic                       out_en,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic [NUBITS-1:0]          data_out,
  output logic                       itr,
  input  logic [NUIOIN*NUBITS-1:0]   in_data,
  input  logic [NUIOIN-1:0]          in_vld,
  output logic [NUIOIN-1:0]          in_rdy,
  output logic [NUIOOU*NUBITS-1:0]   out_data,
  output logic [NUIOOU-1:0]          out_stb
);

  localparam int CNT_W = $clog2(ITRHLD + 1);

  logic [NUBITS-1:0] slot_data [NUIOIN];
  logic [NUIOIN-1:0] capture;
  logic [NUIOIN-1:0] take;
  logic              itr_event;
  itr_state_t        state;
  logic              pending;
  logic [CNT_W-1:0]  cnt;

  for (genvar k = 0; k < NUIOIN; k++) begin : g_slot
    assign take[k] = req_in && (int'(addr_in) == k);

    io_in_slot #(
      .NUBITS(NUBITS)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load_data(in_data[slice_lo(k, NUBITS) +: NUBITS]),
      .load_vld (in_vld[k]),
      .take     (take[k]),
      .rdy      (in_rdy[k]),
      .capture  (capture[k]),
      .data     (slot_data[k])
    );
  end

  // Read mux toward the core; an address past the last port reads as zero
  always_comb begin
    io_in = '0;
    for (int i = 0; i < NUIOIN; i++) begin
      if (int'(addr_in) == i) io_in = slot_data[i];
    end
  end

  // Output port registers with a one-cycle strobe per write; out-of-range addresses match no port
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data <= '0;
      out_stb  <= '0;
    end else begin
      for (int i = 0; i < NUIOOU; i++) begin
        out_stb[i] <= out_en && (int'(addr_out) == i);
        if (out_en && (int'(addr_out) == i)) begin
          out_data[slice_lo(i, NUBITS) +: NUBITS] <= data_out;
        end
      end
    end
  end

  assign itr_event = |(capture & ITRMSK);

  // Interrupt pulse with holdoff; events arriving while busy collapse into a single pending pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= 1'b0;
      cnt     <= '0;
      itr     <= 1'b0;
    end else begin
      itr <= 1'b0;
      case (state)
        IDLE: begin
          if (itr_event || pending) begin
            state   <= FIRE;
            pending <= 1'b0;
            itr     <= 1'b1;
          end
        end
        FIRE: begin
          state <= HOLD;
          cnt   <= CNT_W'(ITRHLD - 1);
          if (itr_event) pending <= 1'b1;
        end
        HOLD: begin
          if (itr_event) pending <= 1'b1;
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_bridge.sv
// Scoreboard bench for io_bridge: reads, writes and interrupt pulses are checked by monitors.
module tb_io_bridge;

  localparam int NB = 32;
  localparam int NI = 8;
  localparam int NO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_in;
  logic [2:0]      addr_in;
  logic [NB-1:0]   io_in;
  logic            out_en;
  logic [2:0]      addr_out;
  logic [NB-1:0]   data_out;
  logic            itr;
  logic [NI*NB-1:0] in_data;
  logic [NI-1:0]   in_vld;
  logic [NI-1:0]   in_rdy;
  logic [NO*NB-1:0] out_data;
  logic [NO-1:0]   out_stb;

  typedef struct {
    int            idx;
    logic [NB-1:0] data;
  } wr_t;

  logic [NB-1:0] rd_q[$];
  wr_t           wr_q[$];
  int            itr_q[$];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int c0;
  int b;

  io_bridge #(
    .NUBITS(NB), .NUIOIN(NI), .NUIOOU(NO), .ITRMSK(8'h01), .ITRHLD(4)
  ) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
    .out_en(out_en), .addr_out(addr_out), .data_out(data_out), .itr(itr),
    .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
    .out_data(out_data), .out_stb(out_stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Read monitor: every core read is compared against the value the stimulus queued
  always @(negedge clk) begin
    if (req_in === 1'b1) begin
      if (rd_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL rd_unexpected: io_in=%0h with no expected read", io_in);
      end else begin
        check("io_in_read", io_in, rd_q.pop_front());
      end
    end
  end

  // Write monitor: each strobe must match the next queued write
  always @(negedge clk) begin
    if (out_stb !== '0) begin
      if (wr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL stb_unexpected: out_stb=%0h, required 0", out_stb);
      end else begin
        wr_t w;
        w = wr_q.pop_front();
        check("out_stb", out_stb, 256'(1) << w.idx);
        check("out_data_slice", out_data[w.idx*NB +: NB], w.data);
      end
    end
  end

  // Interrupt monitor: each pulse must land on the queued cycle
  always @(negedge clk) begin
    if (itr === 1'b1) begin
      if (itr_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL itr_unexpected: itr=1 at cycle %0d, required 0", cyc);
      end else begin
        check("itr_cycle", cyc, itr_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; req_in = 1'b0; addr_in = '0; out_en = 1'b0; addr_out = '0;
    data_out = '0; in_data = '0; in_vld = '0;
    tick(); tick();
    rst = 1'b0;
    settle();
    check("rst_in_rdy", in_rdy, 8'hFF);
    check("rst_out_stb", out_stb, 0);
    check("rst_itr", itr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_io_in", io_in, 0);

    // capture on port 2, read it back, consume
    in_data[2*NB +: NB] = 32'h0000_00A5; in_vld[2] = 1'b1;
    tick();
    in_vld = '0; addr_in = 3'd2;
    settle();
    check("cap_in_rdy", in_rdy, 8'hFB);
    check("cap_io_in", io_in, 32'h0000_00A5);
    req_in = 1'b1; rd_q.push_back(32'h0000_00A5);
    tick();
    req_in = 1'b0;
    settle();
    check("consume_in_rdy", in_rdy, 8'hFF);

    // stale read of an empty port
    addr_in = 3'd5; req_in = 1'b1; rd_q.push_back(32'h0);
    tick();
    req_in = 1'b0;
    settle();
    check("stale_in_rdy", in_rdy, 8'hFF);

    // output writes: single, then back-to-back on the same port, then another port
    out_en = 1'b1; addr_out = 3'd3; data_out = 32'hDEAD_BEEF; wr_q.push_back('{3, 32'hDEAD_BEEF});
    tick();
    out_en = 1'b0;
    tick();
    out_en = 1'b1; data_out = 32'h1111_1111; wr_q.push_back('{3, 32'h1111_1111});
    tick();
    data_out = 32'h2222_2222; wr_q.push_back('{3, 32'h2222_2222});
    tick();
    addr_out = 3'd6; data_out = 32'h6666_0006; wr_q.push_back('{6, 32'h6666_0006});
    tick();
    out_en = 1'b0;
    tick();
    settle();
    check("out_port3_final", out_data[3*NB +: NB], 32'h2222_2222);
    check("out_port6_final", out_data[6*NB +: NB], 32'h6666_0006);

    // interrupt with holdoff; two events during HOLD collapse to one pulse 6 cycles later
    tick();
    c0 = cyc;
    in_data[0 +: NB] = 32'h10; in_vld[0] = 1'b1; itr_q.push_back(c0 + 1);
    tick();
    in_vld = '0; addr_in = 3'd0; req_in = 1'b1; rd_q.push_back(32'h10);
    tick();
    req_in = 1'b0; in_data[0 +: NB] = 32'h20; in_vld[0] = 1'b1;
    tick();
    in_vld = '0; req_in = 1'b1; rd_q.push_back(32'h20);
    tick();
    req_in = 1'b0; in_data[0 +: NB] = 32'h30; in_vld[0] = 1'b1;
    tick();
    in_vld = '0; itr_q.push_back(c0 + 7);
    for (int i = 0; i < 8; i++) tick();

    // back-pressure: producer holds valid while the slot is full
    in_data[0 +: NB] = 32'h40; in_vld[0] = 1'b1;
    tick(); tick(); tick();
    settle();
    check("bp_io_in_kept", io_in, 32'h30);
    check("bp_in_rdy0", in_rdy[0], 1'b0);
    b = cyc;
    req_in = 1'b1; rd_q.push_back(32'h30); itr_q.push_back(b + 2);
    tick();
    req_in = 1'b0;
    tick();
    in_vld = '0;
    settle();
    check("bp_new_data", io_in, 32'h40);

    // capture on unmasked port 1 must not interrupt
    for (int i = 0; i < 6; i++) tick();
    in_data[1*NB +: NB] = 32'h55; in_vld[1] = 1'b1;
    tick();
    in_vld = '0;
    settle();
    check("p1_in_rdy", in_rdy, 8'hFC);
    for (int i = 0; i < 10; i++) tick();

    // reset in HOLD with all slots full and a pulse pending
    req_in = 1'b1; addr_in = 3'd0; rd_q.push_back(32'h40);
    tick();
    req_in = 1'b0;
    for (int k = 0; k < NI; k++) in_data[k*NB +: NB] = 32'h100 + k;
    in_vld = 8'hFF; itr_q.push_back(cyc + 1);
    tick();
    in_vld = '0; req_in = 1'b1; rd_q.push_back(32'h100);
    tick();
    req_in = 1'b0; in_vld[0] = 1'b1;
    tick();
    in_vld = '0;
    settle();
    check("pre_rst_in_rdy", in_rdy, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("mid_rst_in_rdy", in_rdy, 8'hFF);
    check("mid_rst_itr", itr, 0);
    check("mid_rst_out_data", out_data, 0);
    addr_in = 3'd2;
    settle();
    check("mid_rst_io_in", io_in, 0);
    for (int i = 0; i < 12; i++) tick();

    settle();
    check("rd_q_drained", rd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    check("itr_q_drained", itr_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_bridge.md
Name: io_bridge

Overview:
- Peripheral-side end of the processor's I/O interface. Answers the core's input requests (req_in, addr_in -> io_in) and captures its output writes (out_en, addr_out, data_out).
- Holds a one-deep buffer per input port, with a valid/ready handshake toward external producers.
- Holds one register per output port, with a write strobe toward external consumers.
- Generates the single-cycle itr pulse that vectors the core to its interrupt address.
- Instantiated next to core in the processor top level.

Parameters:
- NUBITS, 32, data width; matches the core's data path.
- NUIOIN, 8, number of input ports; must be >= 2.
- NUIOOU, 8, number of output ports; must be >= 2.
- ITRMSK, {NUIOIN{1'b0}}, per-input-port interrupt enable mask, NUIOIN bits.
- ITRHLD, 4, number of cycles itr is held off after a pulse; must be >= 1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_in  in  1  core is consuming the input port selected by addr_in this cycle.
- addr_in  in  $clog2(NUIOIN)  input port select from the core.
- io_in  out  NUBITS  selected input buffer contents, to the core.
- out_en  in  1  core is writing an output port this cycle.
- addr_out  in  $clog2(NUIOOU)  output port select from the core.
- data_out  in  NUBITS  write data from the core.
- itr  out  1  interrupt pulse to the core.
- in_data  in  NUIOIN*NUBITS  external input data; port k occupies bits [k*NUBITS +: NUBITS].
- in_vld  in  NUIOIN  external data valid, per port.
- in_rdy  out  NUIOIN  buffer empty, per port.
- out_data  out  NUIOOU*NUBITS  output port registers, flattened the same way as in_data.
- out_stb  out  NUIOOU  one-cycle pulse when an output port is written.

Behaviour:
- Reset: one-cycle synchronous rst at a clock edge clears everything, including mid-handshake or mid-holdoff:
  - all input buffers = 0, all full flags = 0, so in_rdy = all ones;
  - out_data = 0, out_stb = 0, itr = 0;
  - interrupt FSM in IDLE, pending flag = 0, holdoff counter = 0.
- Input capture:
  - Port k loads in_data slice k and sets full[k] on an edge where in_vld[k] & in_rdy[k].
  - in_rdy[k] = ~full[k], driven directly from the register (no combinational path from req_in).
  - Producers hold in_vld and data stable until accepted.
- Input consume:
  - io_in = buffer[addr_in], combinational; data is valid the same cycle addr_in is valid.
  - On an edge with req_in = 1, full[addr_in] clears; the buffer contents are retained.
  - req_in on an empty port returns the stale buffer value and leaves the flags unchanged.
  - Consume and capture on the same port cannot coincide, because capture requires empty. A port consumed at edge N can accept new data at edge N+1 at the earliest.
- Output write:
  - On an edge with out_en = 1, out_data[addr_out] <= data_out and out_stb[addr_out] = 1 for exactly the following cycle.
  - Back-to-back writes to the same port give one strobe per write.
  - Out-of-range addr_in or addr_out (NUIOIN or NUIOOU not a power of 2) is ignored: io_in reads 0 and no write occurs.
- Interrupt FSM (states IDLE, FIRE, HOLD):
  - An event is any capture on port k with ITRMSK[k] = 1.
  - IDLE: event (or pending = 1) -> FIRE, clearing pending.
  - FIRE: itr = 1 for exactly one cycle, then -> HOLD with counter = ITRHLD-1.
  - HOLD: counter decrements each cycle; at 0 -> IDLE. Events seen during FIRE or HOLD set pending.
  - Multiple events collapse into one pending pulse.
  - itr is registered (state == FIRE); it rises the cycle after the triggering capture edge.
  - With ITRMSK = 0, itr stays 0 permanently.

Decomposition:
- Package io_bridge_pkg:
  - FSM state encoding (IDLE = 2'd0, FIRE = 2'd1, HOLD = 2'd2);
  - port-slice index helper constants.
- Sub-module io_in_slot: one input buffer with full flag, capture and consume logic. Instantiated NUIOIN times in a generate loop.
- The interrupt FSM and the output registers stay in the top module.

Test Plan:
- Reset then capture: release rst; drive in_vld[2] = 1 with data 0x0000_00A5 -> in_rdy[2] falls next cycle. With addr_in = 2, io_in = 0x0000_00A5. Pulse req_in -> in_rdy[2] = 1 the next cycle.
- Stale read: req_in with addr_in = 5 on an empty port -> io_in = 0 after reset; full and in_rdy unchanged.
- Output strobe: out_en = 1, addr_out = 3, data_out = 0xDEAD_BEEF -> out_data slice 3 = 0xDEAD_BEEF and out_stb = 0b0000_1000 for one cycle. Two consecutive writes -> two strobes.
- Interrupt with holdoff (ITRMSK = 8'h01, ITRHLD = 4):
  - capture on port 0 -> itr high for exactly 1 cycle, one cycle after the capture edge;
  - a second capture during HOLD -> second itr pulse no earlier than 4 cycles after the first;
  - a capture on port 1 -> no itr.
- Back-pressure: hold in_vld[0] high while full -> no overwrite; new data accepted only after the req_in consume.
- Reset mid-operation: assert rst during HOLD with full = 8'hFF -> next cycle itr = 0, in_rdy = 8'hFF, FSM in IDLE, no leftover pending pulse.
